sync_fifo_burst_reader: RTL and testbench
=========================================

// Module: sync_fifo_burst_reader
// PURPOSE
//  Read-side master for sync_fifo: drains a commanded burst of words over the FIFO's master handshake.
//  - Connects i_valid_m/i_datain to sync_fifo o_valid_m/o_dataout, and o_ready_m to sync_fifo i_ready_m.
//  - Presents each accepted word downstream with a strobe, plus a running word count and checksum.
//  - Signals burst completion with a done pulse, and optionally a timeout.
// PARAMETERS
//  DATA_WIDTH      `DATA_WIDTH  width of FIFO data word
//  LEN_WIDTH       8            width of burst length / word counter
//  TIMEOUT_CYCLES  64           stall cycles before abort (only with SYNC_FIFO_RD_TIMEOUT_EN)
// PORTS
//  i_clk        in   1           clock
//  i_rst        in   1           reset, synchronous, active-high
//  i_start      in   1           burst command strobe, sampled in IDLE only
//  i_burst_len  in   LEN_WIDTH   words to read, latched on accepted i_start
//  i_valid_m    in   1           FIFO has data (from sync_fifo o_valid_m)
//  i_datain     in   DATA_WIDTH  FIFO head word (from sync_fifo o_dataout)
//  o_ready_m    out  1           pop request (to sync_fifo i_ready_m)
//  o_busy       out  1           burst in progress (state != IDLE)
//  o_data_en    out  1           1-cycle strobe: o_dataout holds a newly read word
//  o_dataout    out  DATA_WIDTH  last word read
//  o_word_cnt   out  LEN_WIDTH   words read in current/last burst
//  o_checksum   out  DATA_WIDTH  sum mod 2^DATA_WIDTH of words read in burst
//  o_done       out  1           1-cycle burst-complete pulse
//  o_timeout    out  1           1-cycle, coincident with o_done when burst aborted by stall
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 on the edge where i_rst=1.
//  - Reset mid-burst: returns to IDLE on the next edge; words already popped are discarded.
//  - Transfer rule: a word transfers on a rising edge with i_valid_m && o_ready_m.
//    - FIFO head is first-word-fall-through: i_datain is valid whenever i_valid_m=1.
//  - o_ready_m = (state==READ); decoded from the state register only, no dependence on i_valid_m.
//  - IDLE, i_start=1, len!=0: latch len; clear o_word_cnt and o_checksum; next state READ.
//    - o_ready_m rises in the cycle after i_start.
//  - IDLE, i_start=1, len==0: next state DONE; zero words read; o_done pulses.
//  - i_start while busy: ignored.
//  - READ, on each transfer:
//    - o_dataout<=i_datain; o_data_en<=1; o_word_cnt<=+1; o_checksum<=o_checksum+i_datain (wraps).
//    - If o_word_cnt+1==len, next state DONE; no further pops.
//  - DONE: o_done=1 for one cycle, o_ready_m=0, next state IDLE.
//    - Last-word o_data_en coincides with o_done.
//    - o_word_cnt and o_checksum hold until the next accepted i_start.
//  - Throughput: 1 word/cycle while i_valid_m stays high. Burst of N with FIFO pre-filled: i_start->o_done = N+1 cycles.
//  - len = 2^LEN_WIDTH-1 is the maximum; the counter never wraps within a burst.
// CONFIGURATION
//  SYNC_FIFO_RD_TIMEOUT_EN defined:
//   - Stall counter runs in READ; cleared on each transfer and on entry to READ.
//   - Counter reaching TIMEOUT_CYCLES consecutive cycles with no transfer: next state DONE, o_timeout=1 with o_done.
//   - o_word_cnt shows the partial count.
//  SYNC_FIFO_RD_TIMEOUT_EN undefined: no counter; o_timeout tied 0; READ waits indefinitely.
// STRUCTURE
//  - sync_fifo_pkg: typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DONE} rd_state_t; shared LEN_WIDTH default.
//  - Single module; no sub-module. FSM, counters and checksum are inline.
// TESTING (bench: sync_fifo + this reader, DATA_WIDTH=8, LEN_WIDTH=8)
//  - Prefill FIFO with 1..10, start len=10 -> o_ready_m high 10 cycles, 10 strobes of 1..10, o_checksum=55, o_done 11 cycles after i_start.
//  - FIFO empty, start len=4, write 4 words, one every 3 cycles -> pops only when i_valid_m=1, o_word_cnt=4, single o_done.
//  - start len=0 -> o_done next cycle, o_ready_m never high, o_word_cnt=0, o_checksum=0.
//  - i_rst=1 after 3 of 8 words -> all outputs 0 on the next edge, FIFO holds the 5 unread words, new start len=5 reads them.
//  - Prefill 0xFF x2, len=2 -> checksum 0xFE (wrap). i_start pulsed during READ -> ignored, burst length unchanged.
//  - TIMEOUT_EN, TIMEOUT_CYCLES=16, 3 words then starve -> o_done and o_timeout 16 cycles after last transfer, o_word_cnt=3.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and defaults for the sync_fifo read-side blocks.
// DATA_WIDTH default is 8.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } rd_state_t;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_LEN_WIDTH      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_burst_reader.sv
// Burst read master for sync_fifo: pops a commanded number of words, strobing each downstream.
// Optional stall abort is enabled with the SYNC_FIFO_RD_TIMEOUT_EN macro.
module sync_fifo_burst_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
`ifdef SYNC_FIFO_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_burst_len,
    input  logic                  i_valid_m,
    input  logic [DATA_WIDTH-1:0] i_datain,
    output logic                  o_ready_m,
    output logic                  o_busy,
    output logic                  o_data_en,
    output logic [DATA_WIDTH-1:0] o_dataout,
    output logic [LEN_WIDTH-1:0]  o_word_cnt,
    output logic [DATA_WIDTH-1:0] o_checksum,
    output logic                  o_done,
    output logic                  o_timeout
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    rd_state_t             state_q;
    rd_state_t             state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  word_cnt_inc;
    logic                  start_ok;
    logic                  xfer;
    logic                  last_word;
    logic                  stall_expired;

    assign start_ok     = (state_q == ST_IDLE) && i_start;
    assign xfer         = i_valid_m && o_ready_m;
    assign word_cnt_inc = o_word_cnt + LEN_ONE;
    assign last_word    = (word_cnt_inc == len_q);

    // NOTE: every clocked process uses non-blocking assignments so all state
    // updates see the pre-edge values, independent of process ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: each combinational process assigns defaults first so no path
    // leaves an output unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = (i_burst_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if ((xfer && last_word) || stall_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status decode from the state register only.
    always_comb begin
        o_ready_m = 1'b0;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state_q)
            ST_READ: begin
                o_ready_m = 1'b1;
                o_busy    = 1'b1;
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Count and checksum are cleared by an accepted start and then hold past done.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q      <= '0;
            o_data_en  <= 1'b0;
            o_dataout  <= '0;
            o_word_cnt <= '0;
            o_checksum <= '0;
        end else begin
            o_data_en <= 1'b0;
            if (start_ok) begin
                len_q      <= i_burst_len;
                o_word_cnt <= '0;
                o_checksum <= '0;
            end
            if (xfer) begin
                o_dataout  <= i_datain;
                o_data_en  <= 1'b1;
                o_word_cnt <= word_cnt_inc;
                o_checksum <= o_checksum + i_datain;
            end
        end
    end

`ifdef SYNC_FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               timeout_q;

    // Counts consecutive READ cycles without a transfer; the last one forces DONE.
    assign stall_expired = (state_q == ST_READ) && !xfer && (stall_cnt == STALL_LAST);
    assign o_timeout     = timeout_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= stall_expired;
            if ((state_q != ST_READ) || xfer) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + STALL_ONE;
            end
        end
    end
`else
    assign stall_expired = 1'b0;
    assign o_timeout     = 1'b0;
`endif

endmodule : sync_fifo_burst_reader

// File: tb/tb_sync_fifo_burst_reader.sv
// Self-checking bench for sync_fifo_burst_reader with a behavioural first-word-fall-through FIFO.
// Adds a stall-abort sequence when SYNC_FIFO_RD_TIMEOUT_EN is defined.
module tb_sync_fifo_burst_reader;

    localparam int BUDGET = 600;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_burst_len;
    logic       i_valid_m = 1'b0;
    logic [7:0] i_datain = '0;
    logic       o_ready_m;
    logic       o_busy;
    logic       o_data_en;
    logic [7:0] o_dataout;
    logic [7:0] o_word_cnt;
    logic [7:0] o_checksum;
    logic       o_done;
    logic       o_timeout;

    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] fifo_q[$];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [7:0] first;
        logic [7:0] step;
        int         fill;
        logic [7:0] len;
        int         poke;
        logic [7:0] exp_cs;
        logic [7:0] exp_last;
        int         exp_lat;
    } vec_t;

    vec_t vecs[7];

    sync_fifo_burst_reader #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8)
`ifdef SYNC_FIFO_RD_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_burst_len(i_burst_len),
        .i_valid_m  (i_valid_m),
        .i_datain   (i_datain),
        .o_ready_m  (o_ready_m),
        .o_busy     (o_busy),
        .o_data_en  (o_data_en),
        .o_dataout  (o_dataout),
        .o_word_cnt (o_word_cnt),
        .o_checksum (o_checksum),
        .o_done     (o_done),
        .o_timeout  (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // FIFO model: pop on handshake, push on write, outputs registered like the real FIFO.
    always @(posedge i_clk) begin
        if (i_valid_m && o_ready_m) void'(fifo_q.pop_front());
        if (wr_en) fifo_q.push_back(wr_data);
        i_valid_m <= (fifo_q.size() != 0);
        i_datain  <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic prefill(input logic [7:0] first, input logic [7:0] step, input int n);
        for (int k = 0; k < n; k++) begin
            wr_en   = 1'b1;
            wr_data = 8'(first + k * step);
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Issues one burst and checks strobes, latency, counters and the done pulse.
    task automatic run_burst(input string name, input logic [7:0] first, input logic [7:0] step,
                             input logic [7:0] len, input int poke, input logic [7:0] exp_cs,
                             input logic [7:0] exp_last, input int exp_lat);
        int  cyc = 0;
        int  strobes = 0;
        int  readys = 0;
        int  extra_done = 0;
        bit  done_seen = 0;
        bit  to_seen = 0;
        logic [7:0] hold_cnt;
        logic [7:0] hold_cs;
        i_start     = 1'b1;
        i_burst_len = len;
        while (!done_seen && cyc < BUDGET) begin
            tick();
            cyc++;
            i_start     = (cyc == poke);
            i_burst_len = 8'd9;
            if (o_ready_m) readys++;
            if (o_timeout) to_seen = 1;
            if (o_data_en) begin
                check({name, "_data"}, o_dataout, 8'(first + strobes * step));
                strobes++;
            end
            if (o_done) done_seen = 1;
        end
        i_start = 1'b0;
        check({name, "_done_seen"}, done_seen, 1);
        if (exp_lat != 0) begin
            check({name, "_latency"}, cyc, exp_lat);
            check({name, "_ready_cycles"}, readys, len);
        end
        check({name, "_strobes"}, strobes, len);
        check({name, "_word_cnt"}, o_word_cnt, len);
        check({name, "_checksum"}, o_checksum, exp_cs);
        check({name, "_last_word"}, o_dataout, exp_last);
        check({name, "_no_timeout"}, to_seen, 0);
        hold_cnt = o_word_cnt;
        hold_cs  = o_checksum;
        tick();
        check({name, "_busy_after"}, o_busy, 0);
        for (int k = 0; k < 3; k++) begin
            if (o_done) extra_done++;
            if (k < 2) tick();
        end
        check({name, "_single_done"}, extra_done, 0);
        check({name, "_cnt_hold"}, o_word_cnt, hold_cnt);
        check({name, "_cs_hold"}, o_checksum, hold_cs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"len10",  8'h01, 8'h01, 10,  8'd10,  -1, 8'h37, 8'h0A, 11};
        vecs[1] = '{"len0",   8'h00, 8'h00, 0,   8'd0,   -1, 8'h00, 8'h0A, 1};
        vecs[2] = '{"wrap",   8'hFF, 8'h00, 2,   8'd2,   -1, 8'hFE, 8'hFF, 3};
        vecs[3] = '{"len1",   8'h5A, 8'h00, 1,   8'd1,   -1, 8'h5A, 8'h5A, 2};
        vecs[4] = '{"poke",   8'h40, 8'h01, 6,   8'd3,   2,  8'hC3, 8'h42, 4};
        vecs[5] = '{"rest",   8'h43, 8'h01, 0,   8'd3,   -1, 8'hCC, 8'h45, 4};
        vecs[6] = '{"maxlen", 8'h00, 8'h01, 255, 8'd255, -1, 8'h81, 8'hFE, 256};

        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_burst_len = '0;
        tick();
        tick();
        check("rst_ready", o_ready_m, 0);
        check("rst_busy", o_busy, 0);
        check("rst_outputs", {o_data_en, o_dataout, o_word_cnt, o_checksum, o_done, o_timeout}, 0);
        i_rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            prefill(vecs[v].first, vecs[v].step, vecs[v].fill);
            run_burst(vecs[v].name, vecs[v].first, vecs[v].step, vecs[v].len, vecs[v].poke,
                      vecs[v].exp_cs, vecs[v].exp_last, vecs[v].exp_lat);
        end
        check("fifo_drained", fifo_q.size(), 0);

        // Slow writer: one word every three cycles into an empty FIFO.
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    wr_en   = 1'b1;
                    wr_data = 8'(8'h11 * (k + 1));
                    tick();
                    wr_en = 1'b0;
                    tick();
                    tick();
                end
            end
            run_burst("slow", 8'h11, 8'h11, 8'd4, -1, 8'hAA, 8'h44, 0);
        join

        // Reset in the cycle of the third pop of an 8-word burst.
        prefill(8'h21, 8'h01, 8);
        i_start     = 1'b1;
        i_burst_len = 8'd8;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        check("pre_rst_cnt", o_word_cnt, 2);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_ready", o_ready_m, 0);
        check("midrst_busy", o_busy, 0);
        check("midrst_outputs", {o_data_en, o_dataout, o_word_cnt, o_checksum, o_done, o_timeout}, 0);
        check("midrst_fifo_left", fifo_q.size(), 5);
        run_burst("after_rst", 8'h24, 8'h01, 8'd5, -1, 8'hBE, 8'h28, 6);

`ifdef SYNC_FIFO_RD_TIMEOUT_EN
        begin
            int  cyc = 0;
            int  last_cyc = 0;
            bit  done_seen = 0;
            bit  to_at_done = 0;
            prefill(8'h07, 8'h01, 3);
            i_start     = 1'b1;
            i_burst_len = 8'd8;
            while (!done_seen && cyc < BUDGET) begin
                tick();
                cyc++;
                i_start = 1'b0;
                if (o_data_en) last_cyc = cyc;
                if (o_done) begin
                    done_seen  = 1;
                    to_at_done = o_timeout;
                end
            end
            check("to_done_seen", done_seen, 1);
            check("to_stall_cycles", cyc - last_cyc, 16);
            check("to_flag", to_at_done, 1);
            check("to_word_cnt", o_word_cnt, 3);
            check("to_checksum", o_checksum, 8'h18);
            tick();
            check("to_flag_pulse", o_timeout, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo_burst_reader
